// File: rtl/mem_writeback_stage.sv
// MEM and WB stages of the DLX pipeline back end.
// EX/MEM register -> data memory access and branch resolution -> MEM/WB
// register -> register-file write-back bus. No hazard handling in here:
// flushing after a taken branch and operand forwarding are the caller's job.
module mem_writeback_stage #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  M_control,
  input  logic [1:0]  WB_control,
  input  logic        zero,
  input  logic [31:0] ALU_out,
  input  logic [31:0] data_write,
  input  logic [4:0]  WB_register,
  input  logic [9:0]  branch_target,
  output logic [31:0] busw,
  output logic [4:0]  rw,
  output logic        reg_write,
  output logic        PC_sel,
  output logic [9:0]  jump_address,
  output logic        mem_fault
);

  // DEPTH expressed at the width of a zero-extended word index.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // An access is out of range when any address bit above the word index is
  // set, or when the word index lands past the last implemented word.
  function automatic logic addr_out_of_range(input logic [31:0] addr);
    logic [ADDR_W:0] idx_ext;
    idx_ext = {1'b0, addr[ADDR_W+1:2]};
    return (addr[31:ADDR_W+2] != '0) || (idx_ext >= DEPTH_L);
  endfunction

  // ---------------- EX/MEM register ----------------
  logic [3:0]  r_exm_mctrl;
  logic [1:0]  r_exm_wbctrl;
  logic        r_exm_zero;
  logic [31:0] r_exm_alu;
  logic [31:0] r_exm_wdata;
  logic [4:0]  r_exm_wbreg;
  logic [9:0]  r_exm_target;

  // ---------------- MEM/WB register ----------------
  logic [31:0] r_mwb_rdata;
  logic [31:0] r_mwb_alu;
  logic [4:0]  r_mwb_wbreg;
  logic [1:0]  r_mwb_wbctrl;
  logic        r_mem_fault;

  // ---------------- data memory ----------------
  logic [31:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_index;
  logic              w_oor;
  logic              w_mem_rd;
  logic              w_mem_wr;
  logic              w_mem_we;
  logic              w_fault_evt;
  logic [31:0]       w_rd_data;

  assign w_index     = r_exm_alu[ADDR_W+1:2];
  assign w_oor       = addr_out_of_range(r_exm_alu);
  assign w_mem_rd    = r_exm_mctrl[2];
  assign w_mem_wr    = r_exm_mctrl[1];
  assign w_mem_we    = w_mem_wr & ~w_oor;
  assign w_fault_evt = (w_mem_rd | w_mem_wr) & w_oor;

  // Read data: current contents for an in-range load, zero otherwise.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    if (w_mem_rd && !w_oor) begin
      w_rd_data = r_mem[w_index];
    end else begin
      w_rd_data = 32'h0000_0000;
    end
  end

  // EX/MEM capture: every cycle, no stall or enable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_exm_mctrl  <= 4'b0000;
      r_exm_wbctrl <= 2'b00;
      r_exm_zero   <= 1'b0;
      r_exm_alu    <= 32'h0000_0000;
      r_exm_wdata  <= 32'h0000_0000;
      r_exm_wbreg  <= 5'd0;
      r_exm_target <= 10'd0;
    end else begin
      r_exm_mctrl  <= M_control;
      r_exm_wbctrl <= WB_control;
      r_exm_zero   <= zero;
      r_exm_alu    <= ALU_out;
      r_exm_wdata  <= data_write;
      r_exm_wbreg  <= WB_register;
      r_exm_target <= branch_target;
    end
  end

  // Store commit; a store sitting in EX/MEM on a reset edge is dropped.
  // Contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (reset_n && w_mem_we) begin
      r_mem[w_index] <= r_exm_wdata;
    end
  end

  // MEM/WB capture; read data sampled before the same-edge store lands.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_mwb_rdata  <= 32'h0000_0000;
      r_mwb_alu    <= 32'h0000_0000;
      r_mwb_wbreg  <= 5'd0;
      r_mwb_wbctrl <= 2'b00;
    end else begin
      r_mwb_rdata  <= w_rd_data;
      r_mwb_alu    <= r_exm_alu;
      r_mwb_wbreg  <= r_exm_wbreg;
      r_mwb_wbctrl <= r_exm_wbctrl;
    end
  end

  // Sticky fault flag: set by any out-of-range access, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_mem_fault <= 1'b0;
    end else if (w_fault_evt) begin
      r_mem_fault <= 1'b1;
    end else begin
      r_mem_fault <= r_mem_fault;
    end
  end

  // Branch resolution straight from EX/MEM: BOP selects the zero polarity.
  assign PC_sel       = r_exm_mctrl[3] & (r_exm_zero ^ r_exm_mctrl[0]);
  assign jump_address = r_exm_target;

  // Write-back bus straight from MEM/WB; r0 is never written.
  assign busw      = r_mwb_wbctrl[0] ? r_mwb_rdata : r_mwb_alu;
  assign rw        = r_mwb_wbreg;
  assign reg_write = r_mwb_wbctrl[1] & (r_mwb_wbreg != 5'd0);
  assign mem_fault = r_mem_fault;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Scoreboard bench for mem_writeback_stage: each applied instruction pushes
// its expected branch outcome (due one cycle later) and write-back result
// (due two cycles later); entries are popped and compared when due.
module tb_mem_writeback_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  M_control;
  logic [1:0]  WB_control;
  logic        zero;
  logic [31:0] ALU_out;
  logic [31:0] data_write;
  logic [4:0]  WB_register;
  logic [9:0]  branch_target;
  logic [31:0] busw;
  logic [4:0]  rw;
  logic        reg_write;
  logic        PC_sel;
  logic [9:0]  jump_address;
  logic        mem_fault;

  always #5 clock = ~clock;

  mem_writeback_stage #(.ADDR_W(8), .DEPTH(256)) dut (
    .clock(clock), .reset_n(reset_n), .M_control(M_control),
    .WB_control(WB_control), .zero(zero), .ALU_out(ALU_out),
    .data_write(data_write), .WB_register(WB_register),
    .branch_target(branch_target), .busw(busw), .rw(rw),
    .reg_write(reg_write), .PC_sel(PC_sel), .jump_address(jump_address),
    .mem_fault(mem_fault)
  );

  typedef struct {
    int          due;
    logic [31:0] busw;
    logic [4:0]  rw;
    logic        we;
    logic        fault;
    logic        pcsel;
    logic [9:0]  ja;
  } exp_t;

  exp_t br_q[$];
  exp_t wb_q[$];

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  logic [31:0] mdl_mem [256];
  logic        mdl_fault = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_due();
    exp_t e;
    while (br_q.size() != 0 && br_q[0].due <= cyc) begin
      e = br_q.pop_front();
      check_val("pc_sel", {31'd0, PC_sel}, {31'd0, e.pcsel});
      check_val("jump_address", {22'd0, jump_address}, {22'd0, e.ja});
    end
    while (wb_q.size() != 0 && wb_q[0].due <= cyc) begin
      e = wb_q.pop_front();
      check_val("busw", busw, e.busw);
      check_val("rw", {27'd0, rw}, {27'd0, e.rw});
      check_val("reg_write", {31'd0, reg_write}, {31'd0, e.we});
      check_val("mem_fault", {31'd0, mem_fault}, {31'd0, e.fault});
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check_due();
  endtask

  task automatic drive(input logic [3:0] mc, input logic [1:0] wbc, input logic z,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input logic [9:0] bt);
    M_control = mc; WB_control = wbc; zero = z; ALU_out = alu;
    data_write = wd; WB_register = wr; branch_target = bt;
  endtask

  // Apply one instruction at the EX/MEM inputs and record its expectations.
  task automatic apply(input logic [3:0] mc, input logic [1:0] wbc, input logic z,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input logic [9:0] bt);
    exp_t        e;
    logic        oor;
    logic [7:0]  idx;
    logic [31:0] rd;
    oor = (alu[31:10] != 22'd0);
    idx = alu[9:2];
    rd  = 32'd0;
    if (mc[2] && !oor) rd = mdl_mem[idx];
    if (mc[1] && !oor) mdl_mem[idx] = wd;
    if ((mc[2] || mc[1]) && oor) mdl_fault = 1'b1;
    e.due   = cyc + 1;
    e.pcsel = mc[3] & (z ^ mc[0]);
    e.ja    = bt;
    e.busw  = 32'd0; e.rw = 5'd0; e.we = 1'b0; e.fault = 1'b0;
    br_q.push_back(e);
    e.due   = cyc + 2;
    e.busw  = wbc[0] ? rd : alu;
    e.rw    = wr;
    e.we    = wbc[1] && (wr != 5'd0);
    e.fault = mdl_fault;
    wb_q.push_back(e);
    drive(mc, wbc, z, alu, wd, wr, bt);
    tick();
  endtask

  task automatic nop();
    apply(4'b0000, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 10'd0);
  endtask

  // Hold reset with a pending store on the inputs; everything must read 0.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    drive(4'b0010, 2'b11, 1'b0, 32'd0, 32'hBAD0_BAD0, 5'd3, 10'h3FF);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      check_val("rst_busw", busw, 32'd0);
      check_val("rst_rw", {27'd0, rw}, 32'd0);
      check_val("rst_reg_write", {31'd0, reg_write}, 32'd0);
      check_val("rst_pc_sel", {31'd0, PC_sel}, 32'd0);
      check_val("rst_jump_address", {22'd0, jump_address}, 32'd0);
      check_val("rst_mem_fault", {31'd0, mem_fault}, 32'd0);
    end
    br_q.delete();
    wb_q.delete();
    mdl_fault = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  r;
    reset_n = 1'b0;
    drive(4'b0000, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 10'd0);
    do_reset(2);

    // Seed word 0, then store/load round trip.
    apply(4'b0010, 2'b00, 1'b0, 32'h0000_0000, 32'hA5A5_0001, 5'd0, 10'd0);
    apply(4'b0010, 2'b00, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 10'd0);
    apply(4'b0100, 2'b11, 1'b0, 32'h0000_0010, 32'd0, 5'd5, 10'd0);
    // Byte offset bits are ignored.
    apply(4'b0100, 2'b11, 1'b0, 32'h0000_0013, 32'd0, 5'd6, 10'd0);

    // ALU write-back; r0 destination suppresses reg_write.
    apply(4'b0000, 2'b10, 1'b0, 32'h0000_1234, 32'd0, 5'd7, 10'd0);
    apply(4'b0000, 2'b10, 1'b0, 32'h0000_1234, 32'd0, 5'd0, 10'd0);

    // Branch polarity combinations.
    apply(4'b1000, 2'b00, 1'b1, 32'd0, 32'd0, 5'd0, 10'h02A);
    apply(4'b1000, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 10'h02A);
    apply(4'b1001, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 10'h155);
    apply(4'b1001, 2'b00, 1'b1, 32'd0, 32'd0, 5'd0, 10'h0FF);
    apply(4'b0000, 2'b00, 1'b1, 32'd0, 32'd0, 5'd0, 10'h3C3);

    // Back-to-back store then load of the same word.
    apply(4'b0010, 2'b00, 1'b0, 32'h0000_0020, 32'h1111_1111, 5'd0, 10'd0);
    apply(4'b0100, 2'b11, 1'b0, 32'h0000_0020, 32'd0, 5'd8, 10'd0);

    // Load+store in one instruction returns the old word.
    apply(4'b0010, 2'b00, 1'b0, 32'h0000_0030, 32'h0000_0001, 5'd0, 10'd0);
    apply(4'b0110, 2'b11, 1'b0, 32'h0000_0030, 32'h0000_0002, 5'd9, 10'd0);
    apply(4'b0100, 2'b11, 1'b0, 32'h0000_0030, 32'd0, 5'd10, 10'd0);

    // Out-of-range store and load: no write, zero data, sticky fault.
    apply(4'b0000, 2'b10, 1'b0, 32'h0000_0055, 32'd0, 5'd11, 10'd0);
    apply(4'b0010, 2'b00, 1'b0, 32'h0000_0400, 32'hFFFF_FFFF, 5'd0, 10'd0);
    apply(4'b0100, 2'b11, 1'b0, 32'h0000_0000, 32'd0, 5'd12, 10'd0);
    apply(4'b0100, 2'b11, 1'b0, 32'h0000_0400, 32'd0, 5'd13, 10'd0);
    apply(4'b0100, 2'b11, 1'b0, 32'h8000_0010, 32'd0, 5'd14, 10'd0);
    nop();
    nop();

    // A store in EX/MEM at the reset edge must be discarded.
    drive(4'b0010, 2'b00, 1'b0, 32'h0000_0000, 32'h0BAD_0BAD, 5'd0, 10'd0);
    tick();
    do_reset(2);
    apply(4'b0100, 2'b11, 1'b0, 32'h0000_0000, 32'd0, 5'd15, 10'd0);
    apply(4'b0100, 2'b11, 1'b0, 32'h0000_0010, 32'd0, 5'd16, 10'd0);

    // Random mix over a small window of initialised words.
    for (int i = 0; i < 8; i++) begin
      apply(4'b0010, 2'b00, 1'b0, 32'h40 + 32'(i * 4), $urandom, 5'd0, 10'd0);
    end
    for (int i = 0; i < 60; i++) begin
      a = 32'h40 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      r = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0: apply(4'b0010, 2'b00, 1'b0, a, d, r, 10'd0);
        1: apply(4'b0100, 2'b11, 1'b0, a, d, r, 10'd0);
        2: apply(4'b0110, 2'b11, 1'b0, a, d, r, 10'd0);
        3: apply(4'b0000, 2'b10, 1'b0, d, d, r, 10'($urandom));
        default: apply({1'b1, 2'b00, 1'($urandom)}, 2'b00, 1'($urandom), d, d, r, 10'($urandom));
      endcase
    end

    // Drain outstanding expectations.
    drive(4'b0000, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 10'd0);
    tick();
    tick();
    if (br_q.size() != 0 || wb_q.size() != 0) begin
      check_val("queue_drain", 32'(br_q.size() + wb_q.size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_writeback_stage.md
Name: mem_writeback_stage

Overview:
- Back end of the MIPS-DLX pipeline: the MEM and WB stages.
- Consumes the EX-stage results (ALU_out, data_write, WB_register, zero, M_control, WB_control) through an EX/MEM register and performs the data-memory access.
- Registers the result in MEM/WB and drives the write-back bus (busw, rw, reg_write) into instruction decode.
- Resolves branches and drives PC_sel/jump_address into instruction fetch.

Parameters:
ADDR_W, 8, data-memory word-address width
DEPTH, 256, number of 32-bit data-memory words (must be ≤ 2^ADDR_W)

Ports:
clock  input  1  single clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
M_control  input  4  [3]=branch, [2]=mem_read, [1]=mem_write, [0]=BOP (0: taken when zero=1; 1: taken when zero=0)
WB_control  input  2  [1]=reg_write, [0]=mem_to_reg
zero  input  1  ALU zero flag from EX
ALU_out  input  32  ALU result / memory byte address from EX
data_write  input  32  store data from EX
WB_register  input  5  destination register from EX
branch_target  input  10  branch target PC from EX
busw  output  32  write-back data to register file
rw  output  5  write-back register index
reg_write  output  1  register-file write enable
PC_sel  output  1  1 = fetch selects jump_address
jump_address  output  10  branch target to fetch
mem_fault  output  1  sticky out-of-range access flag

Behaviour:
- Reset: if reset_n=0 at an edge, all EX/MEM and MEM/WB fields clear to 0. Outputs: busw=0, rw=0, reg_write=0, PC_sel=0, jump_address=0, mem_fault=0. Memory array contents are not reset. Reset mid-operation discards both in-flight instructions; a store held in EX/MEM at that edge is not committed.
- Edge E1: EX/MEM captures all inputs unconditionally every cycle. No stall or enable.
- Branch, combinational from EX/MEM:
  - PC_sel = branch & (zero XOR BOP).
  - jump_address = registered branch_target.
  - PC_sel is valid the cycle after E1, for exactly one cycle.
- Memory address: word index = registered ALU_out[ADDR_W+1:2]. Byte bits [1:0] are ignored.
- Out of range: ALU_out[31:ADDR_W+2] ≠ 0, or index ≥ DEPTH.
- Edge E2, store (mem_write=1, in range): array[index] <= data_write.
- Edge E2, load (mem_read=1): MEM/WB captures array[index] (read-before-write). In range reads return current contents.
- Edge E2, MEM/WB also captures ALU_out, WB_register and WB_control.
- Load and store bits both set: store performed; captured read data is the pre-write contents.
- Out-of-range load or store: store suppressed, read data = 0, mem_fault set at E2. mem_fault stays set until reset.
- Back-to-back: a load in the cycle after a store to the same word sees the new value.
- Write-back, combinational from MEM/WB, valid the cycle after E2:
  - busw = mem_to_reg ? read_data : alu_result.
  - rw = registered WB_register.
  - reg_write = registered reg_write bit.
- reg_write is forced 0 when rw=0 (r0 is never written). busw and rw still reflect the registered values.
- Latency: 1 cycle EX→branch decision; 2 cycles EX→write-back.
- No internal hazard handling: flushing after PC_sel and forwarding belong to the caller.

Test Plan:
- Reset: hold reset_n=0 two cycles with M_control=4'b0010, ALU_out=0 → no store committed, all outputs 0; later load of address 0 returns prior contents.
- Store/load: store data_write=32'hDEADBEEF at ALU_out=32'h10, then load ALU_out=32'h10 with WB_control=2'b11, WB_register=5 → two cycles after the load, busw=32'hDEADBEEF, rw=5, reg_write=1.
- ALU write-back: M_control=0, WB_control=2'b10, ALU_out=32'h1234, WB_register=7 → busw=32'h1234, rw=7, reg_write=1, 2 cycles later; WB_register=0 → reg_write=0.
- Branch: M_control=4'b1000 with zero=1, branch_target=10'h2A → PC_sel=1, jump_address=10'h2A for one cycle. Same with zero=0 → PC_sel=0. BOP=1 with zero=0 → PC_sel=1.
- Out of range: store to ALU_out=32'h400 (index 256, DEPTH=256) → memory unchanged, mem_fault=1 and sticky. A subsequent load of 32'h400 → busw=0.
- Load+store same word: M_control=4'b0110, WB_control=2'b11, old word 32'h1, data_write 32'h2 → busw=32'h1, next load returns 32'h2.
